// File: rtl/ccip_rd_arb_if.sv
// Bundle of the thread-side request/response signals and the CCI-P C0
// Tx/Rx signals shared by ccip_rd_arb and its environment.
interface ccip_rd_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2,
  parameter int ADDR_W  = 42
);
  // Thread request side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_W-1:0]     req_addr;
  logic [NUM_REQ*(16-TAG_W)-1:0] req_mdata;
  logic [NUM_REQ-1:0]            req_ready;
  // C0 Tx toward the shim
  logic                          c0tx_valid;
  logic [ADDR_W-1:0]             c0tx_addr;
  logic [15:0]                   c0tx_mdata;
  logic                          c0tx_almfull;
  // C0 Rx from the shim
  logic                          c0rx_rsp_valid;
  logic [15:0]                   c0rx_mdata;
  logic [511:0]                  c0rx_data;
  // Routed responses to the threads
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [16-TAG_W-1:0]           rsp_mdata;
  logic [511:0]                  rsp_data;

  modport slave (
    input  req_valid, req_addr, req_mdata, c0tx_almfull,
           c0rx_rsp_valid, c0rx_mdata, c0rx_data,
    output req_ready, c0tx_valid, c0tx_addr, c0tx_mdata,
           rsp_valid, rsp_mdata, rsp_data
  );

  modport master (
    output req_valid, req_addr, req_mdata, c0tx_almfull,
           c0rx_rsp_valid, c0rx_mdata, c0rx_data,
    input  req_ready, c0tx_valid, c0tx_addr, c0tx_mdata,
           rsp_valid, rsp_mdata, rsp_data
  );
endinterface

// File: rtl/ccip_rd_arb.sv
// Round-robin arbiter sharing the CCI-P C0 Tx read channel among NUM_REQ
// threads. Issued mdata carries the requester index in its top bits so the
// C0 Rx response can be routed back; per-thread credit counters cap the
// number of reads each thread may have outstanding.
module ccip_rd_arb #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_W     = 2,
  parameter int MAX_OUTST = 32,
  parameter int ADDR_W    = 42
) (
  input  logic                 Clk_400,
  input  logic                 SoftReset_n,
  ccip_rd_arb_if.slave         bus,
  output logic [NUM_REQ*8-1:0] outst_cnt,
  output logic                 idle,
  output logic                 err_underflow
);

  localparam int         MDW     = 16 - TAG_W;
  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTST);

  logic [TAG_W-1:0]  ptr_q, ptr_d;
  logic [7:0]        cnt_q [NUM_REQ];
  logic [7:0]        cnt_d [NUM_REQ];
  logic              c0tx_valid_q, c0tx_valid_d;
  logic [ADDR_W-1:0] c0tx_addr_q, c0tx_addr_d;
  logic [15:0]       c0tx_mdata_q, c0tx_mdata_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [MDW-1:0]    rsp_mdata_q, rsp_mdata_d;
  logic [511:0]      rsp_data_q, rsp_data_d;
  logic              err_underflow_q, err_underflow_d;

  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               gnt_found_s;
  logic [TAG_W-1:0]   gnt_idx_s;
  logic [TAG_W-1:0]   rsp_tag_s;

  // Eligibility: credit left, shim not almost full, and not held in reset
  // (a grant during the reset cycle would be accepted by the thread but lost).
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = bus.req_valid[i] && (cnt_q[i] < MAX_CNT) &&
                  !bus.c0tx_almfull && SoftReset_n;
    end
  end

  // Round-robin search starting at ptr; first eligible thread wins.
  always_comb begin : arb
    logic [TAG_W-1:0] idx;
    idx         = '0;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    grant_s     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr_q + TAG_W'(k);
      if (!gnt_found_s && elig_s[idx]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = idx;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    grant_s[gnt_idx_s] = gnt_found_s;
  end

  assign bus.req_ready = grant_s;
  assign rsp_tag_s     = bus.c0rx_mdata[15 -: TAG_W];

  // Next-state for pointer, issue register, response register and credits.
  always_comb begin
    ptr_d           = gnt_found_s ? (gnt_idx_s + TAG_W'(1)) : ptr_q;
    c0tx_valid_d    = gnt_found_s;
    c0tx_addr_d     = c0tx_addr_q;
    c0tx_mdata_d    = c0tx_mdata_q;
    rsp_mdata_d     = bus.c0rx_mdata[MDW-1:0];
    rsp_data_d      = bus.c0rx_data;
    rsp_valid_d     = '0;
    err_underflow_d = err_underflow_q;
    cnt_d           = cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        c0tx_addr_d  = bus.req_addr[i*ADDR_W +: ADDR_W];
        c0tx_mdata_d = {TAG_W'(i), bus.req_mdata[i*MDW +: MDW]};
      end else begin
        c0tx_addr_d  = c0tx_addr_d;
      end
      rsp_valid_d[i] = bus.c0rx_rsp_valid && (rsp_tag_s == TAG_W'(i));
      if (grant_s[i] && !rsp_valid_d[i]) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end else if (!grant_s[i] && rsp_valid_d[i]) begin
        if (cnt_q[i] == 8'd0) begin
          cnt_d[i]        = 8'd0;
          err_underflow_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 8'd1;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State registers with synchronous active-low reset; responses in reset are dropped.
  always_ff @(posedge Clk_400) begin
    if (!SoftReset_n) begin
      ptr_q           <= '0;
      cnt_q           <= '{default: 8'd0};
      c0tx_valid_q    <= 1'b0;
      c0tx_addr_q     <= '0;
      c0tx_mdata_q    <= 16'd0;
      rsp_valid_q     <= '0;
      rsp_mdata_q     <= '0;
      rsp_data_q      <= 512'd0;
      err_underflow_q <= 1'b0;
    end else begin
      ptr_q           <= ptr_d;
      cnt_q           <= cnt_d;
      c0tx_valid_q    <= c0tx_valid_d;
      c0tx_addr_q     <= c0tx_addr_d;
      c0tx_mdata_q    <= c0tx_mdata_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_mdata_q     <= rsp_mdata_d;
      rsp_data_q      <= rsp_data_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  // Flatten counters and derive idle from registered state only.
  always_comb begin
    outst_cnt = '0;
    idle      = !c0tx_valid_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      outst_cnt[i*8 +: 8] = cnt_q[i];
      if (cnt_q[i] != 8'd0) begin
        idle = 1'b0;
      end else begin
        idle = idle;
      end
    end
  end

  assign bus.c0tx_valid = c0tx_valid_q;
  assign bus.c0tx_addr  = c0tx_addr_q;
  assign bus.c0tx_mdata = c0tx_mdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_mdata  = rsp_mdata_q;
  assign bus.rsp_data   = rsp_data_q;
  assign err_underflow  = err_underflow_q;

endmodule

// File: tb/tb_ccip_rd_arb.sv
// Scoreboard bench for ccip_rd_arb: stimulus pushes expected C0 Tx issues
// and routed responses into queues; a negedge monitor pops and compares.
module tb_ccip_rd_arb;
  localparam int NUM_REQ   = 4;
  localparam int TAG_W     = 2;
  localparam int MAX_OUTST = 32;
  localparam int ADDR_W    = 42;
  localparam int MDW       = 16 - TAG_W;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       mdata;
  } iss_t;

  typedef struct {
    logic [NUM_REQ-1:0] v;
    logic [MDW-1:0]     md;
    logic [511:0]       d;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_REQ*8-1:0] outst_cnt;
  logic idle;
  logic err_underflow;
  int   total = 0;
  int   bad = 0;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  always #5 clk = ~clk;

  ccip_rd_arb_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) bus ();

  ccip_rd_arb #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MAX_OUTST(MAX_OUTST),
                .ADDR_W(ADDR_W)) dut (
    .Clk_400      (clk),
    .SoftReset_n  (rst_n),
    .bus          (bus),
    .outst_cnt    (outst_cnt),
    .idle         (idle),
    .err_underflow(err_underflow)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  // Check req_ready and queue the expected issue for the granted thread.
  task automatic grant_chk(input logic [NUM_REQ-1:0] exp_rdy);
    check("req_ready", bus.req_ready, exp_rdy);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_rdy[i]) begin
        iss_q.push_back('{addr: bus.req_addr[i*ADDR_W +: ADDR_W],
                          mdata: {TAG_W'(i), bus.req_mdata[i*MDW +: MDW]}});
      end
    end
  endtask

  task automatic cyc(input logic [NUM_REQ-1:0] exp_rdy);
    mid();
    grant_chk(exp_rdy);
    fin();
  endtask

  task automatic set_payload(input int c);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i * 4096 + c);
      bus.req_mdata[i*MDW +: MDW]      = MDW'(i * 256 + c);
    end
  endtask

  // Drive a response in the current cycle and queue its routed form.
  task automatic drive_rsp(input int tag, input logic [MDW-1:0] md, input logic [31:0] w);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[tag] = 1'b1;
    bus.c0rx_rsp_valid = 1'b1;
    bus.c0rx_mdata     = {TAG_W'(tag), md};
    bus.c0rx_data      = {16{w}};
    rsp_q.push_back('{v: oh, md: md, d: {16{w}}});
  endtask

  task automatic clear_rsp();
    bus.c0rx_rsp_valid = 1'b0;
    bus.c0rx_mdata     = 16'd0;
    bus.c0rx_data      = 512'd0;
  endtask

  // Monitor: every DUT output beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.c0tx_valid === 1'b1) begin
      if (iss_q.size() == 0) begin
        check("c0tx_spurious", 1, 0);
      end else begin
        iss_t e;
        e = iss_q.pop_front();
        check("c0tx_addr", bus.c0tx_addr, e.addr);
        check("c0tx_mdata", bus.c0tx_mdata, e.mdata);
      end
    end
    if (bus.rsp_valid !== '0) begin
      if (rsp_q.size() == 0) begin
        check("rsp_spurious", bus.rsp_valid, 0);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("rsp_valid", bus.rsp_valid, r.v);
        check("rsp_mdata", bus.rsp_mdata, r.md);
        check("rsp_data", bus.rsp_data, r.d);
      end
    end
  end

  initial begin
    bus.req_valid    = '0;
    bus.req_addr     = '0;
    bus.req_mdata    = '0;
    bus.c0tx_almfull = 1'b0;
    clear_rsp();
    rst_n = 1'b0;
    repeat (2) fin();
    rst_n = 1'b1;

    // Reset state
    mid();
    check("rst_outst", outst_cnt, 0);
    check("rst_idle", idle, 1);
    check("rst_err", err_underflow, 0);
    check("rst_c0tx_valid", bus.c0tx_valid, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    grant_chk(4'b0000);
    fin();

    // All four threads stream until every credit is used
    bus.req_valid = 4'hF;
    for (int c = 0; c < 128; c++) begin
      set_payload(c);
      cyc(4'(1 << (c % 4)));
    end
    mid();
    check("full_outst", outst_cnt, {4{8'd32}});
    grant_chk(4'b0000);
    check("full_idle", idle, 0);
    fin();

    // Only thread 2, pointer moves to 3 after its first grant
    bus.req_valid = 4'b0000;
    rst_n = 1'b0;
    fin();
    rst_n = 1'b1;
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 32; c++) begin
      set_payload(200 + c);
      cyc(4'b0100);
    end
    mid();
    check("t2_full_cnt", outst_cnt[23:16], 8'd32);
    grant_chk(4'b0000);
    fin();
    for (int r = 0; r < 3; r++) begin
      drive_rsp(2, MDW'(14'h100 + r), 32'hA0 + 32'(r));
      cyc(4'b0000);
      clear_rsp();
      set_payload(240 + r);
      mid();
      check("t2_reopen_cnt", outst_cnt[23:16], 8'd31);
      grant_chk(4'b0100);
      fin();
      cyc(4'b0000);
    end

    // Almost-full window
    rst_n = 1'b0;
    fin();
    rst_n = 1'b1;
    bus.req_valid = 4'hF;
    set_payload(300);
    cyc(4'b0001);
    set_payload(301);
    cyc(4'b0010);
    bus.c0tx_almfull = 1'b1;
    for (int w = 0; w < 10; w++) begin
      mid();
      grant_chk(4'b0000);
      if (w > 0) check("almfull_c0tx_valid", bus.c0tx_valid, 0);
      fin();
    end
    bus.c0tx_almfull = 1'b0;
    set_payload(302);
    cyc(4'b0100);

    // Simultaneous accept and response for thread 1 at count 5
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_payload(310 + k);
      cyc(4'b0010);
    end
    set_payload(320);
    drive_rsp(1, 14'h155, 32'hDEADBEEF);
    mid();
    check("t1_cnt_before", outst_cnt[15:8], 8'd5);
    grant_chk(4'b0010);
    fin();
    clear_rsp();
    bus.req_valid = 4'b0000;
    mid();
    check("t1_cnt_after", outst_cnt[15:8], 8'd5);
    fin();

    // Underflow on thread 3
    drive_rsp(3, 14'h2A5, 32'h12345678);
    mid();
    check("uf_err_before", err_underflow, 0);
    fin();
    clear_rsp();
    mid();
    check("uf_err_set", err_underflow, 1);
    check("uf_cnt3", outst_cnt[31:24], 8'd0);
    fin();
    repeat (2) fin();
    mid();
    check("uf_err_sticky", err_underflow, 1);
    fin();

    // Reset mid-traffic; ptr is 2 here
    bus.req_valid = 4'hF;
    set_payload(400);
    cyc(4'b0100);
    set_payload(401);
    cyc(4'b1000);
    set_payload(402);
    cyc(4'b0001);
    rst_n = 1'b0;
    mid();
    grant_chk(4'b0000);
    fin();
    rst_n = 1'b1;
    set_payload(403);
    mid();
    check("mr_outst", outst_cnt, 0);
    check("mr_err", err_underflow, 0);
    check("mr_idle", idle, 1);
    check("mr_c0tx_valid", bus.c0tx_valid, 0);
    check("mr_rsp_valid", bus.rsp_valid, 0);
    grant_chk(4'b0001);
    fin();
    set_payload(404);
    cyc(4'b0010);
    bus.req_valid = 4'b0000;
    repeat (3) cyc(4'b0000);

    check("issue_q_drained", iss_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ccip_rd_arb.md
# ccip_rd_arb

Round-robin arbiter that shares the CCI-P C0 Tx read-request channel among NUM_REQ independent AFU test threads in the multi-threaded NLB-style AFU, running in the AFU clock domain behind the async shim. Tags each issued request's mdata with the requester index. Routes C0 Rx read responses back to the owning thread by tag. Enforces a per-thread outstanding-request credit limit so no thread can starve the others.

## Interface
Parameters:
- NUM_REQ, 4: number of requesting threads; power of two, 2..8.
- TAG_W, 2: log2(NUM_REQ); requester index width.
- MAX_OUTST, 32: maximum outstanding reads per thread, 1..255.
- ADDR_W, 42: cache-line address width.

Ports:
- Clk_400  in  1  AFU clock; all logic on rising edge.
- SoftReset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-thread read request valid.
- req_addr  in  NUM_REQ*ADDR_W  per-thread CL address; thread i at [i*ADDR_W +: ADDR_W].
- req_mdata  in  NUM_REQ*(16-TAG_W)  per-thread user mdata.
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- c0tx_valid  out  1  read request valid toward the shim.
- c0tx_addr  out  ADDR_W  issued address.
- c0tx_mdata  out  16  issued mdata: {tag, user mdata}, with tag in [15:16-TAG_W].
- c0tx_almfull  in  1  C0 Tx almost-full from the shim.
- c0rx_rsp_valid  in  1  read response valid.
- c0rx_mdata  in  16  response mdata.
- c0rx_data  in  512  response data.
- rsp_valid  out  NUM_REQ  one-hot routed response valid.
- rsp_mdata  out  16-TAG_W  user mdata of the routed response; broadcast to all threads.
- rsp_data  out  512  response data; broadcast to all threads.
- outst_cnt  out  NUM_REQ*8  per-thread outstanding count.
- idle  out  1  high when every outstanding count is 0 and c0tx_valid is 0.
- err_underflow  out  1  sticky error flag.

## Operation
- Eligibility: thread i is eligible when req_valid[i], outst_cnt[i] < MAX_OUTST, and c0tx_almfull == 0.
- Arbitration: round-robin with pointer ptr.
  - Search eligible threads starting at ptr, wrapping at NUM_REQ.
  - The first eligible thread gets req_ready for one cycle; at most one bit of req_ready is set.
  - After a grant to thread g, ptr = (g+1) mod NUM_REQ.
  - With no grant, ptr holds.
- Issue: the accepted request is registered onto c0tx_*.
  - c0tx_mdata = {g[TAG_W-1:0], req_mdata[g]}.
  - c0tx_valid pulses for exactly one cycle per acceptance.
- Credit counters, thread i:
  - +1 on acceptance by i.
  - -1 on a response whose tag == i.
  - Both in the same cycle: unchanged.
  - A decrement at 0 saturates at 0 and sets err_underflow.
  - The counter never exceeds MAX_OUTST.
- Response routing:
  - tag = c0rx_mdata[15:16-TAG_W].
  - rsp_valid[tag] is registered from c0rx_rsp_valid.
  - rsp_mdata is registered from c0rx_mdata[15-TAG_W:0]; rsp_data is registered from c0rx_data.
- err_underflow clears only on reset.
- Reset: when SoftReset_n == 0 at an edge:
  - ptr, all counters, c0tx_valid, req_ready, rsp_valid, and err_underflow go to 0.
  - c0tx_addr, c0tx_mdata, rsp_mdata, and rsp_data go to 0.
  - idle reads 1.
  - Responses arriving while in reset are dropped.
  - Reset asserted mid-burst discards any issued-but-unanswered bookkeeping; counters restart at 0.

## Timing
- req_ready is combinational from req_valid, the counters, ptr, and c0tx_almfull in the same cycle.
- Accept in cycle N puts c0tx_valid high in cycle N+1; issue latency is 1.
- c0tx_almfull is sampled in the grant cycle.
  - almfull high in cycle N means no grant in N.
  - At most 1 request is issued after almfull rises, and the shim tolerates that.
- Response at the input in cycle N puts rsp_valid high in cycle N+1.
  - The counter decrement is visible in outst_cnt in cycle N+1.
- outst_cnt and the increment:
  - outst_cnt is registered.
  - The increment for an accept in cycle N is visible in cycle N+1.
  - Eligibility in cycle N+1 uses the updated count.
- Throughput:
  - One request per cycle sustained while any thread is eligible.
  - One response per cycle with no backpressure; threads must always accept rsp_valid.

## Test plan
- Reset, then all four threads request continuously with MAX_OUTST=32 and no responses:
  - Grants go 0,1,2,3,0,…
  - After 128 accepts every outst_cnt = 32 and req_ready = 0.
  - c0tx_mdata[15:14] follows the grant order.
- Only thread 2 valid, with ptr = 3:
  - Thread 2 is granted every cycle until outst_cnt[2] = MAX_OUTST.
  - Responses with tag 2 reopen exactly one grant each.
- c0tx_almfull held high for 10 cycles with all threads valid:
  - Zero grants during the window.
  - c0tx_valid drops one cycle after almfull rises.
  - The first grant after almfull deasserts goes to the thread at ptr.
- Simultaneous accept and response for thread 1 with outst_cnt[1] = 5:
  - outst_cnt[1] stays 5.
  - rsp_valid = 4'b0010 in the next cycle, with rsp_data matching the input.
- Response with tag 3 while outst_cnt[3] = 0:
  - err_underflow rises and stays set.
  - Counter stays 0.
  - rsp_valid[3] is still asserted.
- SoftReset_n low for 1 cycle mid-traffic:
  - All counters, ptr, valids, and err_underflow are 0 on the next cycle.
  - idle = 1.
  - Arbitration restarts at thread 0.
